// File: rtl/dfc_receiver.sv
`default_nettype none
// ============================================================================
// Module   : dfc_receiver
// Function : delayed-flow-control link terminator with skid FIFO, srdy/drdy out.
//            Optional sticky overflow flag enabled by DFC_RECEIVER_OVFL_EN.
// Revision : 1.0
// ============================================================================
module dfc_receiver #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             c_vld,
  output logic             c_fc_n,
  input  logic [WIDTH-1:0] c_data,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [WIDTH-1:0] p_data
`ifdef DFC_RECEIVER_OVFL_EN
  ,
  output logic             ovfl
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DELAY);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             c_fc_n_q, c_fc_n_d;
  logic             full, push, pop;

  always_comb begin
    full     = (count_q == DEPTH_C);
    pop      = p_srdy & p_drdy;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push     = c_vld & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    // Keep room for every word still in flight once the sender sees the stop.
    c_fc_n_d = ((DEPTH_C - count_d) > DELAY_C);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      c_fc_n_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      c_fc_n_q <= c_fc_n_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wr_ptr_q] <= c_data;
  end

  assign p_srdy = (count_q != '0);
  assign p_data = mem_q[rd_ptr_q];
  assign c_fc_n = c_fc_n_q;

`ifdef DFC_RECEIVER_OVFL_EN
  logic ovfl_q, ovfl_d;

  always_comb begin
    ovfl_d = ovfl_q | (c_vld & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) ovfl_q <= 1'b0;
    else        ovfl_q <= ovfl_d;
  end

  assign ovfl = ovfl_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dfc_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_dfc_receiver
// Function : directed self-checking bench for dfc_receiver (depth 8 and depth 5).
// Revision : 1.0
// ============================================================================
module tb_dfc_receiver;

  logic       clk;
  logic       reset;
  logic       c_vld,  c_vld5;
  logic       c_fc_n, c_fc_n5;
  logic [7:0] c_data, c_data5;
  logic       p_srdy, p_srdy5;
  logic       p_drdy, p_drdy5;
  logic [7:0] p_data, p_data5;
`ifdef DFC_RECEIVER_OVFL_EN
  logic       ovfl, ovfl5;
`endif

  int tests = 0;
  int fails = 0;

  dfc_receiver #(.WIDTH(8), .DEPTH(8), .DELAY(2)) u_dut (
    .clk(clk), .reset(reset), .c_vld(c_vld), .c_fc_n(c_fc_n), .c_data(c_data),
    .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data)
`ifdef DFC_RECEIVER_OVFL_EN
    , .ovfl(ovfl)
`endif
  );

  dfc_receiver #(.WIDTH(8), .DEPTH(5), .DELAY(2)) u_dut5 (
    .clk(clk), .reset(reset), .c_vld(c_vld5), .c_fc_n(c_fc_n5), .c_data(c_data5),
    .p_srdy(p_srdy5), .p_drdy(p_drdy5), .p_data(p_data5)
`ifdef DFC_RECEIVER_OVFL_EN
    , .ovfl(ovfl5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_word;
    logic       fc_prev;
    int         sent, got, cyc;

    reset = 1'b0; c_vld = 1'b1; c_data = 8'hAA; p_drdy = 1'b0;
    c_vld5 = 1'b0; c_data5 = 8'h00; p_drdy5 = 1'b0;

    // Reset held for three edges while the link is busy.
    repeat (3) tick();
    chk("rst_srdy", 32'(p_srdy), 0);
    chk("rst_fc",   32'(c_fc_n), 0);
    chk("rst_cnt",  32'(u_dut.count_q), 0);
`ifdef DFC_RECEIVER_OVFL_EN
    chk("rst_ovfl", 32'(ovfl), 0);
`endif
    reset = 1'b1; c_vld = 1'b0;
    tick();
    chk("fc_rise",  32'(c_fc_n), 1);
    chk("idle_srdy", 32'(p_srdy), 0);

    // Streaming at full rate.
    p_drdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      c_vld = 1'b1; c_data = 8'(i);
      tick();
      chk("stream_data", 32'(p_data), 32'(i));
      chk("stream_fc",   32'(c_fc_n), 1);
    end
    c_vld = 1'b0;
    tick();
    chk("stream_empty", 32'(p_srdy), 0);

    // Backpressure: stop seen at count 6, then two in-flight words.
    p_drdy = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      c_vld = 1'b1; c_data = 8'(8'h20 + i);
      tick();
      chk("bp_fc", 32'(c_fc_n), (i == 6) ? 32'd0 : 32'd1);
    end
    for (int i = 7; i <= 8; i++) begin
      c_data = 8'(8'h20 + i);
      tick();
    end
    c_vld = 1'b0;
    chk("bp_cnt",  32'(u_dut.count_q), 8);
    chk("bp_fc0",  32'(c_fc_n), 0);
`ifdef DFC_RECEIVER_OVFL_EN
    chk("bp_ovfl", 32'(ovfl), 0);
`endif
    p_drdy = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      chk("bp_data", 32'(p_data), 32'(8'h20 + j));
      tick();
      chk("bp_fc_ret", 32'(c_fc_n), (j >= 3) ? 32'd1 : 32'd0);
    end
    chk("bp_empty", 32'(p_srdy), 0);

    // Full with simultaneous push and pop.
    p_drdy = 1'b0; c_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_data = 8'(8'h40 + i);
      tick();
    end
    c_data = 8'h48; p_drdy = 1'b1;
    tick();
    c_vld = 1'b0;
    chk("fpp_cnt",  32'(u_dut.count_q), 8);
    chk("fpp_head", 32'(p_data), 32'h41);
    for (int j = 1; j <= 8; j++) begin
      chk("fpp_data", 32'(p_data), 32'(8'h40 + j));
      tick();
    end
    chk("fpp_empty", 32'(p_srdy), 0);

    // Overflow: ninth word into a full FIFO with no pop is dropped.
    p_drdy = 1'b0; c_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c_data = 8'(8'h60 + i);
      tick();
    end
    c_data = 8'h5A;
    tick();
    c_vld = 1'b0;
    chk("ovf_cnt",  32'(u_dut.count_q), 8);
    chk("ovf_head", 32'(p_data), 32'h60);
`ifdef DFC_RECEIVER_OVFL_EN
    chk("ovf_set", 32'(ovfl), 1);
    repeat (10) tick();
    chk("ovf_hold", 32'(ovfl), 1);
`endif
    p_drdy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("ovf_data", 32'(p_data), 32'(8'h60 + j));
      tick();
    end
    chk("ovf_dropped", 32'(p_srdy), 0);

    // Mid-operation reset discards stored words and pops nothing.
    p_drdy = 1'b0; c_vld = 1'b1;
    c_data = 8'h70; tick();
    c_data = 8'h71; tick();
    p_drdy = 1'b1; reset = 1'b0;
    tick();
    chk("mrst_cnt",  32'(u_dut.count_q), 0);
    chk("mrst_srdy", 32'(p_srdy), 0);
    chk("mrst_fc",   32'(c_fc_n), 0);
`ifdef DFC_RECEIVER_OVFL_EN
    chk("mrst_ovfl", 32'(ovfl), 0);
`endif
    reset = 1'b1; c_vld = 1'b0;
    tick();
    chk("mrst_fc1", 32'(c_fc_n), 1);

    // Wrap on a depth-5 instance; sender reacts to flow control one cycle late.
    sent = 0; got = 0; cyc = 0; fc_prev = 1'b0;
    while (got < 20 && cyc < 400) begin
      c_vld5  = (sent < 20) && fc_prev;
      c_data5 = 8'(8'h80 + sent);
      p_drdy5 = 1'($urandom_range(0, 1));
      fc_prev = c_fc_n5;
      chk("wrap_srdy", 32'(p_srdy5), (q.size() != 0) ? 32'd1 : 32'd0);
      if (p_srdy5 && p_drdy5 && q.size() != 0) begin
        exp_word = q.pop_front();
        chk("wrap_data", 32'(p_data5), 32'(exp_word));
        got++;
      end
      tick();
      if (c_vld5) begin
        q.push_back(c_data5);
        sent++;
      end
      chk("wrap_cnt_max", (u_dut5.count_q <= 3'd5) ? 32'd1 : 32'd0, 1);
      cyc++;
    end
    c_vld5 = 1'b0; p_drdy5 = 1'b0;
    chk("wrap_done", 32'(got), 20);
`ifdef DFC_RECEIVER_OVFL_EN
    chk("wrap_ovfl", 32'(ovfl5), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/dfc_receiver.md
# dfc_receiver

Delayed-flow-control receiver: terminates a registered valid/flow-control link and re-presents its data as a standard srdy/drdy interface. Sits directly downstream of the DFC sender, across the registered link. Contains a skid FIFO sized to absorb every word the link can still deliver after flow control is deasserted. Flow control back to the sender is registered, so the sender and receiver together close timing on the link in both directions.

## Interface
- width, 8, data word width in bits
- depth, 8, FIFO entries; must be > delay (any integer, not restricted to powers of two)
- delay, 2, max words the link may still deliver after c_fc_n falls (round-trip of the link)

- clk  in  1  clock; all logic rises on posedge
- reset  in  1  one clock; reset is synchronous and active-low (0 = reset)
- c_vld  in  1  link valid; word on c_data is delivered this cycle
- c_fc_n  out  1  registered flow control to sender; 1 = may send, 0 = stop
- c_data  in  width  link data
- p_srdy  out  1  output word available
- p_drdy  in  1  downstream accepts
- p_data  out  width  output word (head of FIFO)
- ovfl  out  1  sticky overflow error (only with DFC_RECEIVER_OVFL_EN)

## Operation
- Storage: depth x width register array; wr_ptr, rd_ptr of clog2(depth) bits; count of clog2(depth+1) bits.
- Push: c_vld=1 and (count<depth or pop this cycle). Writes c_data at wr_ptr, wr_ptr advances.
- Pop: p_srdy & p_drdy; rd_ptr advances.
- Pointers wrap from depth-1 to 0; no power-of-two assumption.
- count_next = count + push - pop; push and pop in the same cycle leave count unchanged, including at count=depth.
- p_srdy = (count != 0); p_data = mem[rd_ptr] (combinational read of array, no output register).
- Flow control: c_fc_n <= ((depth - count_next) > delay). Guarantees room for delay in-flight words after deassertion.
- Push with count=depth and no pop: word dropped, pointers and count unchanged (protocol violation by sender).
- No bypass path: a word arriving into an empty FIFO is visible one cycle later.

## Timing
- Reset (reset=0 at an edge): count, wr_ptr, rd_ptr <= 0; c_fc_n <= 0; ovfl <= 0. Therefore p_srdy=0. Array contents are not reset. c_vld is ignored while reset=0.
- Reset mid-operation discards all stored words at that edge. Nothing is popped on that edge.
- c_fc_n rises at the first edge with reset=1 (given delay < depth).
- Latency c_vld to p_srdy: 1 cycle.
- Throughput: 1 word/cycle sustained when p_drdy=1.
- c_fc_n changes only on clock edges and depends on count_next, never combinationally on inputs.

## Configuration
- DFC_RECEIVER_OVFL_EN defined: ovfl port exists. ovfl <= 1 at any edge where c_vld=1, count=depth and no pop. It stays 1 until reset. The word is dropped as above.
- Not defined: no ovfl port and no flag register. Overflowing words are dropped silently.

## Test plan
- Reset: reset=0 for 3 cycles with c_vld=1, c_data=0xAA -> p_srdy=0, c_fc_n=0, count=0. First edge after reset=1 -> c_fc_n=1.
- Streaming (width=8, depth=8, delay=2): c_vld=1 with data 0x01..0x10 on consecutive cycles, p_drdy=1 -> p_data sequence 0x01..0x10, each word 1 cycle after input, c_fc_n stays 1.
- Backpressure: p_drdy=0, sender honouring c_fc_n -> c_fc_n=0 at the edge where count reaches 6. The 2 in-flight words fill count to 8, with no loss and no ovfl. Then p_drdy=1 -> 8 words out in order, and c_fc_n returns to 1 at the edge where count_next drops to 5.
- Full with simultaneous push/pop: count=8, c_vld=1, p_drdy=1 -> both occur, count stays 8, new word appears after 7 older ones.
- Overflow (macro on): count=8, c_vld=1, c_data=0x5A, p_drdy=0 -> word dropped, ovfl=1 and held through 10 further idle cycles, cleared only by reset=0.
- Wrap (depth=5, delay=2): 20 words with random p_drdy -> output order and values exactly match input, count never exceeds 5.
